// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between instruction fetch and data access ports.
// One transfer at a time, alternating priority under contention, with a timeout abort.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_D} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  count;
  logic        last_d;
  logic        busy;
  logic        timeout_hit;
  logic        finish;
  logic        grant_d;
  logic [31:0] resp;

  assign busy        = (state != IDLE);
  // An ack in the final allowed cycle wins over the abort.
  assign timeout_hit = busy & ~bus_ack & (count == LIMIT);
  assign finish      = busy & (bus_ack | timeout_hit);
  assign grant_d     = d_req & (~if_req | ~last_d);
  assign resp        = bus_ack ? bus_rdata : 32'h0;

  assign if_ready  = (state == BUS_IF) & finish;
  assign d_ready   = (state == BUS_D) & finish;
  assign if_rdata  = if_ready ? resp : 32'h0;
  assign d_rdata   = d_ready ? resp : 32'h0;
  assign bus_err   = timeout_hit;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 8'h0;
      last_d    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          count <= 8'h0;
          if (grant_d) begin
            state     <= BUS_D;
            bus_req   <= 1'b1;
            bus_we    <= d_we;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            last_d    <= 1'b1;
          end else if (if_req) begin
            state    <= BUS_IF;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= if_addr;
            last_d   <= 1'b0;
          end
        end
        BUS_IF, BUS_D: begin
          if (finish) begin
            state   <= IDLE;
            bus_req <= 1'b0;
          end else begin
            count <= count + 8'h1;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
